fp_add_ctrl: RTL and testbench
==============================

// Module: fp_add_ctrl
// PURPOSE
//   Sequencing FSM for the single-precision FP adder datapath (exponent ULA/register, FP muxes 1-5, fraction shifter, fraction ULA, exp +/-1 ULA, round).
//   Drives the mux selects, align and normalise shift amounts and exponent inc/dec. Reads back exponent difference, sum, rounded fraction and current exponent.
//   One add per start pulse; multi-cycle; sits between the top-level FP unit and datapath fd.
// PARAMETERS
//   FRAC_W    27  fraction bus width: [26]=sign, [25]=carry, [24]=hidden bit, [2:0]=guard/round/sticky
//   EXP_W     8   exponent width
//   MAX_NORM  26  max single-bit normalise steps before forced exit
// PORTS
//   clock            in   1       rising-edge clock
//   reset            in   1       synchronous, active-high
//   start            in   1       begin add; sampled only in IDLE
//   exp_dif          in   8       registered exp(a)-exp(b), two's complement
//   ula              in   27      fraction ULA result
//   round_fract      in   27      round stage fraction output
//   exp_cur          in   8       exp +/-1 ULA output (current exponent)
//   sinalMuxFP1..3   out  1 each  0: a is larger-exp operand; 1: b is larger-exp operand
//   sinalMuxFP4      out  1       0: exponent from MuxFP1; 1: from round stage
//   sinalMuxFP5      out  1       0: fraction from ULA; 1: from round stage
//   sinalShiftFract  out  8       right-align shift amount
//   sinalShiftRes    out  9       [8]=1 left / 0 right, [7:0]=amount (0 or 1)
//   sinalIncOrDec    out  1       0: exp+1, 1: exp-1
//   busy             out  1       high from start accept until DONE exit
//   done             out  1       one-cycle pulse in DONE
//   overflow/underflow/zero out 1 each  result flags, valid while done=1
// BEHAVIOUR
// - Reset: state=IDLE. All outputs 0. Norm counter 0.
//   Reset mid-operation aborts to IDLE next edge with no done pulse.
// - States, 1 cycle each unless noted:
//   IDLE: wait for start.
//   EXPDIF: wait 1 cycle for the exponent register.
//   ALIGN: sel = exp_dif[7]. sinalMuxFP1 = sel, sinalMuxFP2 = sel, sinalMuxFP3 = ~sel.
//     sinalShiftFract = |exp_dif|, clamped to 27.
//     exp_dif = -128: shift = 27 (no wrap).
//   ADD: wait for ULA result.
//   NORM: magnitude = ula[25:0] (or round_fract[25:0] after a round pass).
//     magnitude == 0: zero=1 -> DONE.
//     [25]=1: right 1, inc. exp_cur == 8'hFE before inc: overflow=1 -> DONE.
//     [24]=0: left 1, dec. Stays in NORM.
//       exp_cur == 0: underflow=1 -> ROUND.
//     Else: -> ROUND.
//     Counter reaching MAX_NORM: -> ROUND. Counter clears on leaving NORM.
//   ROUND: round stage registers (RNE on [2:0]).
//   CHECK: sinalMuxFP4 = 1, sinalMuxFP5 = 1.
//     round_fract[25] = 1 and no prior re-norm: one right shift + inc -> NORM.
//     Else: -> DONE.
//     At most one re-normalise per operation.
//   DONE: done=1 for one cycle, busy drops, -> IDLE. Flags hold until next start.
// - Latency, equal exponents, no normalise, no round carry: start at cycle 0, done at cycle 6.
//   Each normalise step adds 1 cycle.
// - start while busy: ignored, no queue. start and reset together: reset wins.
// - Mux selects hold their ALIGN value from ALIGN through DONE.
// TESTING
//   1. 1.0+1.0 (exp 127/127): exp_dif=0, shift=0, carry -> one right/inc; exponent 128; done at cycle 7.
//   2. exp_a=130, exp_b=127: sel=0, sinalShiftFract=3. Swapped operands: sel=1, shift=3.
//   3. exp_dif=-128 or +100: sinalShiftFract=27, no wrap.
//   4. 1.5-1.25: ula magnitude 0x0400000, two left/dec steps; sinalShiftRes=9'h101 each step; done at cycle 8.
//   5. Equal magnitudes, opposite signs: zero=1; done without ROUND.
//   6. exp 254, sum carry: overflow=1. Reset asserted in NORM: IDLE next cycle, outputs 0, no done.

Source files
------------

// File: rtl/fp_add_ctrl.sv
// Sequencing FSM for the single-precision FP adder datapath: operand select, align,
// add, normalise, round and a single post-round re-normalise, with result flags.
module fp_add_ctrl #(
  parameter int unsigned FRAC_W   = 27,
  parameter int unsigned EXP_W    = 8,
  parameter int unsigned MAX_NORM = 26
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [EXP_W-1:0] exp_dif,
  input  logic [FRAC_W-1:0] ula,
  input  logic [FRAC_W-1:0] round_fract,
  input  logic [EXP_W-1:0] exp_cur,
  output logic             sinalMuxFP1,
  output logic             sinalMuxFP2,
  output logic             sinalMuxFP3,
  output logic             sinalMuxFP4,
  output logic             sinalMuxFP5,
  output logic [EXP_W-1:0] sinalShiftFract,
  output logic [EXP_W:0]   sinalShiftRes,
  output logic             sinalIncOrDec,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             underflow,
  output logic             zero
);

  localparam int unsigned MAG_W = FRAC_W - 1;
  localparam int unsigned CNT_W = $clog2(MAX_NORM + 1);

  localparam logic [EXP_W:0]   FRAC_LIM = (EXP_W + 1)'(FRAC_W);
  localparam logic [EXP_W-1:0] EXP_SAT  = EXP_W'((1 << EXP_W) - 2);
  localparam logic [EXP_W:0]   SHR_R1   = {1'b0, EXP_W'(1)};
  localparam logic [EXP_W:0]   SHR_L1   = {1'b1, EXP_W'(1)};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_NORM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXPDIF,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             renorm_q;

  logic [EXP_W:0]   dif_ext_c;
  logic [EXP_W:0]   dif_abs_c;
  logic [EXP_W-1:0] shift_clamp_c;
  logic [MAG_W-1:0] mag_c;
  logic             mag_carry_c;
  logic             mag_hidden_c;
  logic             unused_bits_c;

  // Sign-extend before negating so that -2^(EXP_W-1) yields its true magnitude.
  always_comb begin
    dif_ext_c     = {exp_dif[EXP_W-1], exp_dif};
    dif_abs_c     = exp_dif[EXP_W-1] ? (~dif_ext_c + (EXP_W + 1)'(1)) : dif_ext_c;
    shift_clamp_c = (dif_abs_c > FRAC_LIM) ? FRAC_LIM[EXP_W-1:0] : dif_abs_c[EXP_W-1:0];
  end

  // After a round pass the magnitude under normalisation comes from the round stage.
  always_comb begin
    mag_c        = renorm_q ? round_fract[MAG_W-1:0] : ula[MAG_W-1:0];
    mag_carry_c  = mag_c[MAG_W-1];
    mag_hidden_c = mag_c[MAG_W-2];
  end

  assign unused_bits_c = ula[FRAC_W-1] ^ round_fract[FRAC_W-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      renorm_q        <= 1'b0;
      sinalMuxFP1     <= 1'b0;
      sinalMuxFP2     <= 1'b0;
      sinalMuxFP3     <= 1'b0;
      sinalMuxFP4     <= 1'b0;
      sinalMuxFP5     <= 1'b0;
      sinalShiftFract <= '0;
      sinalShiftRes   <= '0;
      sinalIncOrDec   <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
      zero            <= 1'b0;
    end else begin
      // Shift/step commands and done are single-cycle strobes.
      sinalShiftRes <= '0;
      sinalIncOrDec <= 1'b0;
      done          <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q     <= S_EXPDIF;
            busy        <= 1'b1;
            cnt_q       <= '0;
            renorm_q    <= 1'b0;
            sinalMuxFP4 <= 1'b0;
            sinalMuxFP5 <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            zero        <= 1'b0;
          end
        end

        S_EXPDIF: state_q <= S_ALIGN;

        S_ALIGN: begin
          sinalMuxFP1     <= exp_dif[EXP_W-1];
          sinalMuxFP2     <= exp_dif[EXP_W-1];
          sinalMuxFP3     <= ~exp_dif[EXP_W-1];
          sinalShiftFract <= shift_clamp_c;
          state_q         <= S_ADD;
        end

        S_ADD: state_q <= S_NORM;

        S_NORM: begin
          if (mag_c == '0) begin
            zero    <= 1'b1;
            done    <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else if (cnt_q == CNT_MAX) begin
            cnt_q   <= '0;
            state_q <= S_ROUND;
          end else if (mag_carry_c) begin
            if (exp_cur >= EXP_SAT) begin
              overflow <= 1'b1;
              done     <= 1'b1;
              cnt_q    <= '0;
              state_q  <= S_DONE;
            end else begin
              sinalShiftRes <= SHR_R1;
              sinalIncOrDec <= 1'b0;
              cnt_q         <= CNT_W'(cnt_q + CNT_W'(1));
            end
          end else if (!mag_hidden_c) begin
            if (exp_cur == '0) begin
              underflow <= 1'b1;
              cnt_q     <= '0;
              state_q   <= S_ROUND;
            end else begin
              sinalShiftRes <= SHR_L1;
              sinalIncOrDec <= 1'b1;
              cnt_q         <= CNT_W'(cnt_q + CNT_W'(1));
            end
          end else begin
            cnt_q   <= '0;
            state_q <= S_ROUND;
          end
        end

        S_ROUND: begin
          sinalMuxFP4 <= 1'b1;
          sinalMuxFP5 <= 1'b1;
          state_q     <= S_CHECK;
        end

        // A rounding carry gets exactly one extra right-shift pass.
        S_CHECK: begin
          if (round_fract[MAG_W-1] && !renorm_q) begin
            renorm_q      <= 1'b1;
            sinalShiftRes <= SHR_R1;
            sinalIncOrDec <= 1'b0;
            state_q       <= S_NORM;
          end else begin
            done    <= 1'b1;
            state_q <= S_DONE;
          end
        end

        S_DONE: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_ctrl.sv
// Scoreboard bench for fp_add_ctrl; a reactive model stands in for the adder datapath.
module tb_fp_add_ctrl;

  localparam logic [26:0] RND_CARRY = 27'h2000000;

  typedef struct {
    int          a;
    int          b;
    logic [26:0] u;
    bit          rc;
    bit          xs;
    int          cyc;
    bit          z;
    bit          o;
    bit          un;
    bit          m4;
    int          ef;
    int          nl;
    int          nr;
  } op_t;

  typedef struct {
    int cyc;
    bit sel;
    int shf;
    bit z;
    bit o;
    bit un;
    bit m4;
    int ef;
    int nl;
    int nr;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  exp_dif = '0;
  logic [26:0] ula = '0;
  logic [26:0] round_fract = '0;
  logic [7:0]  exp_cur = '0;
  logic        sinalMuxFP1, sinalMuxFP2, sinalMuxFP3, sinalMuxFP4, sinalMuxFP5;
  logic [7:0]  sinalShiftFract;
  logic [8:0]  sinalShiftRes;
  logic        sinalIncOrDec, busy, done, overflow, underflow, zero;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb_q[$];
  op_t  ops[10];

  // Datapath model state (written only by the model process)
  int          ld_seq = 0;
  int          seen_seq = 0;
  logic [26:0] ld_ula = '0;
  logic [7:0]  ld_exp = '0;
  bit          ld_rc = 1'b0;
  bit          rc = 1'b0;
  int          n_left = 0;
  int          n_right = 0;
  logic [8:0]  last_res = '0;
  logic        last_incdec = 1'b0;

  fp_add_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .exp_dif(exp_dif),
    .ula(ula), .round_fract(round_fract), .exp_cur(exp_cur),
    .sinalMuxFP1(sinalMuxFP1), .sinalMuxFP2(sinalMuxFP2), .sinalMuxFP3(sinalMuxFP3),
    .sinalMuxFP4(sinalMuxFP4), .sinalMuxFP5(sinalMuxFP5),
    .sinalShiftFract(sinalShiftFract), .sinalShiftRes(sinalShiftRes),
    .sinalIncOrDec(sinalIncOrDec), .busy(busy), .done(done),
    .overflow(overflow), .underflow(underflow), .zero(zero)
  );

  always #5 clock = ~clock;

  // Datapath: obeys shift/inc/dec commands; round stage follows the ULA until selected.
  always @(negedge clock) begin
    logic [26:0] u_nxt;
    logic [26:0] r_nxt;
    u_nxt = ula;
    r_nxt = round_fract;
    if (ld_seq != seen_seq) begin
      seen_seq    <= ld_seq;
      ula         <= ld_ula;
      exp_cur     <= ld_exp;
      rc          <= ld_rc;
      round_fract <= ld_rc ? RND_CARRY : ld_ula;
      n_left      <= 0;
      n_right     <= 0;
      last_res    <= '0;
      last_incdec <= 1'b0;
    end else begin
      if (sinalShiftRes[7:0] != 8'd0) begin
        last_res    <= sinalShiftRes;
        last_incdec <= sinalIncOrDec;
        if (sinalShiftRes[8]) n_left <= n_left + 1;
        else n_right <= n_right + 1;
        exp_cur <= sinalIncOrDec ? exp_cur - 8'd1 : exp_cur + 8'd1;
        if (sinalMuxFP5) r_nxt = sinalShiftRes[8] ? round_fract << 1 : round_fract >> 1;
        else u_nxt = sinalShiftRes[8] ? ula << 1 : ula >> 1;
      end
      if (!sinalMuxFP5) r_nxt = rc ? RND_CARRY : u_nxt;
      ula         <= u_nxt;
      round_fract <= r_nxt;
    end
  end

  task automatic check_eq(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  task automatic launch(input op_t o);
    @(posedge clock); #1;
    ld_ula  = o.u;
    ld_exp  = 8'((o.a > o.b) ? o.a : o.b);
    ld_rc   = o.rc;
    ld_seq  = ld_seq + 1;
    exp_dif = 8'(o.a - o.b);
    start   = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input op_t o);
    exp_t e;
    exp_t w;
    int   d;
    int   k;
    int   extra;
    bit   got;
    d = o.a - o.b;
    if (d < 0) d = -d;
    e.cyc = o.cyc; e.sel = (o.a < o.b); e.shf = (d > 27) ? 27 : d;
    e.z = o.z; e.o = o.o; e.un = o.un; e.m4 = o.m4;
    e.ef = o.ef; e.nl = o.nl; e.nr = o.nr;
    sb_q.push_back(e);
    launch(o);
    got = 1'b0;
    k = 0;
    for (int i = 1; i <= 30 && !got; i++) begin
      @(posedge clock); #1;
      if (o.xs) start = (i == 2);
      if (i == 1) check_eq("busy_mid", int'(busy), 1);
      if (done) begin
        got = 1'b1;
        k = i;
      end
    end
    start = 1'b0;
    w = sb_q.pop_front();
    check_eq("done_seen", int'(got), 1);
    if (got) begin
      check_eq("latency", k, w.cyc);
      check_eq("mux1", int'(sinalMuxFP1), int'(w.sel));
      check_eq("mux2", int'(sinalMuxFP2), int'(w.sel));
      check_eq("mux3", int'(sinalMuxFP3), int'(!w.sel));
      check_eq("shift_fract", int'(sinalShiftFract), w.shf);
      check_eq("zero", int'(zero), int'(w.z));
      check_eq("overflow", int'(overflow), int'(w.o));
      check_eq("underflow", int'(underflow), int'(w.un));
      check_eq("mux4", int'(sinalMuxFP4), int'(w.m4));
      check_eq("mux5", int'(sinalMuxFP5), int'(w.m4));
      check_eq("exp_final", int'(exp_cur), w.ef);
      check_eq("left_steps", n_left, w.nl);
      check_eq("right_steps", n_right, w.nr);
      if (w.nl + w.nr > 0) begin
        check_eq("shift_res", int'(last_res), (w.nl > 0) ? 'h101 : 'h001);
        check_eq("inc_dec", int'(last_incdec), (w.nl > 0) ? 1 : 0);
      end
      @(posedge clock); #1;
      check_eq("done_pulse", int'(done), 0);
      check_eq("busy_after", int'(busy), 0);
      extra = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clock); #1;
        if (done) extra++;
      end
      check_eq("no_extra_done", extra, 0);
      check_eq("flags_hold", int'({zero, overflow, underflow}), int'({w.z, w.o, w.un}));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    //          a    b    ula          rc xs cyc z o u m4 exp  nl nr
    ops[0] = '{127, 127, 27'h2000000, 0, 0, 7, 0, 0, 0, 1, 128, 0, 1};
    ops[1] = '{130, 127, 27'h1800000, 0, 1, 6, 0, 0, 0, 1, 130, 0, 0};
    ops[2] = '{127, 130, 27'h1800000, 0, 0, 6, 0, 0, 0, 1, 130, 0, 0};
    ops[3] = '{1,   129, 27'h1000000, 0, 0, 6, 0, 0, 0, 1, 129, 0, 0};
    ops[4] = '{200, 100, 27'h1000000, 0, 0, 6, 0, 0, 0, 1, 200, 0, 0};
    ops[5] = '{127, 127, 27'h0400000, 0, 0, 8, 0, 0, 0, 1, 125, 2, 0};
    ops[6] = '{127, 127, 27'h4000000, 0, 0, 4, 1, 0, 0, 0, 127, 0, 0};
    ops[7] = '{254, 254, 27'h2000000, 0, 0, 4, 0, 1, 0, 0, 254, 0, 0};
    ops[8] = '{127, 127, 27'h1FFFFFF, 1, 0, 9, 0, 0, 0, 1, 128, 0, 1};
    ops[9] = '{0,   0,   27'h0800000, 0, 0, 6, 0, 0, 1, 1, 0,   0, 0};

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    start = 1'b1;
    @(posedge clock); #1;
    check_eq("rst_outputs", int'({sinalMuxFP1, sinalMuxFP2, sinalMuxFP3, sinalMuxFP4,
             sinalMuxFP5, sinalShiftFract, sinalShiftRes, sinalIncOrDec, busy, done,
             overflow, underflow, zero}), 0);
    check_eq("rst_beats_start", int'(busy), 0);
    start = 1'b0;
    reset = 1'b0;

    foreach (ops[i]) run_op(ops[i]);

    // Abort in NORM: two-step left normalise, reset after the first step command.
    launch(ops[5]);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clock); #1;
    end
    check_eq("in_norm_step", int'(sinalShiftRes), 'h101);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_eq("abort_outputs", int'({sinalMuxFP1, sinalMuxFP2, sinalMuxFP3, sinalMuxFP4,
             sinalMuxFP5, sinalShiftFract, sinalShiftRes, sinalIncOrDec, busy, done,
             overflow, underflow, zero}), 0);
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (done || busy) extra++;
    end
    check_eq("abort_quiet", extra, 0);

    run_op(ops[1]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
